// File: rtl/cv32e40s_div_radix_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40s_pkg (divider slice)
//
// Purpose : shared types for the radix divider block.
//   div_opcode_e      - operation selector presented with each request
//   div_radix_state_e - control FSM state of cv32e40s_div_radix, also
//                       exported on the block's debug state output
// ---------------------------------------------------------------------------
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,  // signed quotient
    DIV_DIVU = 2'b01,  // unsigned quotient
    DIV_REM  = 2'b10,  // signed remainder
    DIV_REMU = 2'b11   // unsigned remainder
  } div_opcode_e;

  typedef enum logic [1:0] {
    DIVR_IDLE   = 2'b00,
    DIVR_DIVIDE = 2'b01,
    DIVR_FINISH = 2'b10
  } div_radix_state_e;

endpackage

// File: rtl/cv32e40s_div_radix_if.sv
// ---------------------------------------------------------------------------
// cv32e40s_div_radix_if
//
// Purpose : request/response bundle between a divider user and
//           cv32e40s_div_radix.
//
// Handshake (one rule for the whole bundle):
//   The requester raises valid_i with operator_i/op_a_i/op_b_i/
//   data_ind_timing_i and keeps valid_i high until the result has been
//   taken. Dropping valid_i at any point kills the operation; the divider
//   answers with ready_o=1 in that same cycle. When valid_o is high,
//   result_o is stable; the result is consumed in the cycle where
//   valid_o & ready_i are both high, and ready_o is 1 in that cycle.
//
// Signals :
//   operator_i        div_opcode_e  operation, sampled at accept
//   data_ind_timing_i 1             fixed latency when high at accept
//   op_a_i / op_b_i   WIDTH         dividend / divisor, sampled at accept
//   valid_i           1             request (low = kill)
//   ready_o           1             request consumed or killed
//   valid_o           1             result_o valid
//   ready_i           1             downstream takes the result
//   result_o          WIDTH         quotient or remainder
//
// Modports: master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface cv32e40s_div_radix_if #(
  parameter int WIDTH = 32
);
  import cv32e40s_pkg::*;

  div_opcode_e      operator_i;
  logic             data_ind_timing_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             valid_i;
  logic             ready_o;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;

  modport master (
    output operator_i, data_ind_timing_i, op_a_i, op_b_i, valid_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  operator_i, data_ind_timing_i, op_a_i, op_b_i, valid_i, ready_i,
    output ready_o, valid_o, result_o
  );

endinterface

// File: rtl/cv32e40s_div_clz.sv
// ---------------------------------------------------------------------------
// cv32e40s_div_clz
//
// Purpose : combinational count of leading zeros, used by the divider to
//           normalise the divisor magnitude.
//
// Ports   :
//   i_data  [WIDTH-1:0]          value to scan
//   o_count [$clog2(WIDTH):0]    number of leading zeros; WIDTH for zero
// ---------------------------------------------------------------------------
module cv32e40s_div_clz #(
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  // Scan from LSB upwards; the highest set bit is the last one to write,
  // so it determines the final count.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) begin
        o_count = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/cv32e40s_div_radix.sv
// ---------------------------------------------------------------------------
// cv32e40s_div_radix
//
// Purpose : iterative restoring divider for DIV/DIVU/REM/REMU with early
//           termination from a normalised divisor, optional data-independent
//           latency, and BITS_PER_CYCLE quotient bits per DIVIDE cycle.
//
// Ports   :
//   clk          clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   bus          cv32e40s_div_radix_if.slave (request/result handshake)
//   o_dbg_state  current control FSM state
//
// Operation:
//   Accept (IDLE, valid_i high): magnitudes are formed, the divisor is
//   shifted left by L = clz(|b|) (L = WIDTH-1 for b = 0), and the cycle
//   counter is loaded with N = ceil((L+1)/BITS_PER_CYCLE), or
//   WIDTH/BITS_PER_CYCLE when data_ind_timing_i is high.
//   DIVIDE: N iteration cycles, then one cycle that applies the sign fix
//   into the result register, so valid_o rises N+1 cycles after accept.
//   FINISH: result held until ready_i.
// ---------------------------------------------------------------------------
module cv32e40s_div_radix
  import cv32e40s_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cv32e40s_div_radix_if.slave  bus,
  output div_radix_state_e     o_dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  div_radix_state_e r_state;
  div_opcode_e      r_op;
  logic             r_quot_neg;
  logic             r_rem_neg;
  logic [WIDTH-1:0] r_rem;     // partial remainder (magnitude)
  logic [WIDTH-1:0] r_div;     // normalised divisor, shifts right per step
  logic [WIDTH-1:0] r_quot;    // quotient magnitude, shifts left per step
  logic [CW-1:0]    r_steps;   // real compare-subtract steps still owed
  logic [CW-1:0]    r_cnt;     // DIVIDE iteration cycles still to run
  logic [WIDTH-1:0] r_result;

  // -------------------------------------------------------------------------
  // Accept-time operand preparation
  // -------------------------------------------------------------------------
  logic             w_is_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [CW-1:0]    w_clz;
  logic [CW-1:0]    w_lz;
  logic [WIDTH-1:0] w_norm_div;
  logic [CW-1:0]    w_real_steps;
  logic [CW-1:0]    w_iters;

  assign w_is_signed = (bus.operator_i == DIV_DIV) || (bus.operator_i == DIV_REM);
  assign w_a_neg     = w_is_signed & bus.op_a_i[WIDTH-1];
  assign w_b_neg     = w_is_signed & bus.op_b_i[WIDTH-1];
  assign w_b_zero    = (bus.op_b_i == '0);

  // -MIN wraps to MIN, which read as unsigned is exactly 2^(WIDTH-1).
  assign w_abs_a = w_a_neg ? -bus.op_a_i : bus.op_a_i;
  assign w_abs_b = w_b_neg ? -bus.op_b_i : bus.op_b_i;

  cv32e40s_div_clz #(
    .WIDTH (WIDTH)
  ) u_clz (
    .i_data  (w_abs_b),
    .o_count (w_clz)
  );

  // A zero divisor behaves like a divisor of 1 for the step count; with a
  // zero divisor every step subtracts nothing and sets a quotient bit, which
  // yields all ones as quotient and |a| as remainder.
  assign w_lz         = w_b_zero ? CW'(WIDTH - 1) : w_clz;
  assign w_norm_div   = w_abs_b << w_lz;
  assign w_real_steps = w_lz + CW'(1);

  always_comb begin
    w_iters = w_real_steps;
    if (BITS_PER_CYCLE == 2) begin
      w_iters = (w_real_steps + CW'(1)) >> 1;
    end
    if (bus.data_ind_timing_i) begin
      w_iters = CW'(WIDTH / BITS_PER_CYCLE);
    end
  end

  // -------------------------------------------------------------------------
  // One DIVIDE cycle: BITS_PER_CYCLE restoring steps. Once the real steps are
  // used up (odd L+1 with two bits per cycle, or data-independent padding)
  // the remaining steps are dummies and leave every value untouched.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0] w_quot_nxt;
  logic [CW-1:0]    w_steps_nxt;

  always_comb begin
    w_rem_nxt   = r_rem;
    w_div_nxt   = r_div;
    w_quot_nxt  = r_quot;
    w_steps_nxt = r_steps;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (w_steps_nxt != '0) begin
        if (w_rem_nxt >= w_div_nxt) begin
          w_rem_nxt  = w_rem_nxt - w_div_nxt;
          w_quot_nxt = {w_quot_nxt[WIDTH-2:0], 1'b1};
        end else begin
          w_quot_nxt = {w_quot_nxt[WIDTH-2:0], 1'b0};
        end
        w_div_nxt   = w_div_nxt >> 1;
        w_steps_nxt = w_steps_nxt - CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sign fix. MIN / -1 needs no special case: |MIN| / 1 = 2^(WIDTH-1) with
  // equal signs is not negated and reads back as MIN; remainder is 0.
  // -------------------------------------------------------------------------
  logic             w_is_rem;
  logic [WIDTH-1:0] w_fixed;

  assign w_is_rem = (r_op == DIV_REM) || (r_op == DIV_REMU);

  always_comb begin
    if (w_is_rem) begin
      w_fixed = r_rem_neg ? -r_rem : r_rem;
    end else begin
      w_fixed = r_quot_neg ? -r_quot : r_quot;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  div_radix_state_e w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_fix;
  logic             w_ready;
  logic             w_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    w_ready     = 1'b0;
    w_valid     = 1'b0;

    if (!bus.valid_i) begin
      // Kill (or simply no request): back to IDLE from anywhere.
      w_state_nxt = DIVR_IDLE;
      w_ready     = 1'b1;
    end else begin
      unique case (r_state)
        DIVR_IDLE: begin
          w_load      = 1'b1;
          w_state_nxt = DIVR_DIVIDE;
        end
        DIVR_DIVIDE: begin
          if (r_cnt != '0) begin
            w_step = 1'b1;
          end else begin
            w_fix       = 1'b1;
            w_state_nxt = DIVR_FINISH;
          end
        end
        DIVR_FINISH: begin
          w_valid = 1'b1;
          if (bus.ready_i) begin
            w_ready     = 1'b1;
            w_state_nxt = DIVR_IDLE;
          end
        end
        default: begin
          w_state_nxt = DIVR_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= DIVR_IDLE;
      r_op       <= DIV_DIV;
      r_quot_neg <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_rem      <= '0;
      r_div      <= '0;
      r_quot     <= '0;
      r_steps    <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_op       <= bus.operator_i;
        r_quot_neg <= ~w_b_zero & (w_a_neg ^ w_b_neg);
        r_rem_neg  <= w_a_neg;
        r_rem      <= w_abs_a;
        r_div      <= w_norm_div;
        r_quot     <= '0;
        r_steps    <= w_real_steps;
        r_cnt      <= w_iters;
      end
      if (w_step) begin
        r_rem   <= w_rem_nxt;
        r_div   <= w_div_nxt;
        r_quot  <= w_quot_nxt;
        r_steps <= w_steps_nxt;
        r_cnt   <= r_cnt - CW'(1);
      end
      if (w_fix) begin
        r_result <= w_fixed;
      end
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.valid_o  = w_valid;
  assign bus.result_o = r_result;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_cv32e40s_div_radix.sv
// ---------------------------------------------------------------------------
// tb_cv32e40s_div_radix
//
// Two divider instances: WIDTH=32/BPC=1 and WIDTH=64/BPC=2. One shared set
// of drive variables is steered to the selected instance; the other sees
// valid_i low and idles. Expected results and latencies come from an
// arithmetic model of the divide rules.
// ---------------------------------------------------------------------------
module tb_cv32e40s_div_radix;
  import cv32e40s_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- drive / monitor ----------------
  logic        use64;
  div_opcode_e drv_op;
  logic        drv_dit;
  logic [63:0] drv_a, drv_b;
  logic        drv_valid, drv_ready;

  cv32e40s_div_radix_if #(.WIDTH(32)) if32 ();
  cv32e40s_div_radix_if #(.WIDTH(64)) if64 ();
  div_radix_state_e dbg32, dbg64;

  assign if32.operator_i        = drv_op;
  assign if32.data_ind_timing_i = drv_dit;
  assign if32.op_a_i            = drv_a[31:0];
  assign if32.op_b_i            = drv_b[31:0];
  assign if32.valid_i           = drv_valid & ~use64;
  assign if32.ready_i           = drv_ready & ~use64;
  assign if64.operator_i        = drv_op;
  assign if64.data_ind_timing_i = drv_dit;
  assign if64.op_a_i            = drv_a;
  assign if64.op_b_i            = drv_b;
  assign if64.valid_i           = drv_valid & use64;
  assign if64.ready_i           = drv_ready & use64;

  logic             mon_valid_o, mon_ready_o;
  logic [63:0]      mon_result;
  div_radix_state_e mon_state;
  assign mon_valid_o = use64 ? if64.valid_o  : if32.valid_o;
  assign mon_ready_o = use64 ? if64.ready_o  : if32.ready_o;
  assign mon_result  = use64 ? if64.result_o : {32'h0, if32.result_o};
  assign mon_state   = use64 ? dbg64 : dbg32;

  cv32e40s_div_radix #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave), .o_dbg_state(dbg32));
  cv32e40s_div_radix #(.WIDTH(64), .BITS_PER_CYCLE(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(if64.slave), .o_dbg_state(dbg64));

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [63:0] width_mask(int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] ref_result(div_opcode_e op, logic [63:0] a,
                                             logic [63:0] b, int w);
    logic [63:0] mask, ua, ub, min_v;
    logic        sgn, is_rem;
    longint      sa, sb;
    mask   = width_mask(w);
    sgn    = (op == DIV_DIV) || (op == DIV_REM);
    is_rem = (op == DIV_REM) || (op == DIV_REMU);
    ua     = a & mask;
    ub     = b & mask;
    min_v  = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (w == 32) begin
      sa = longint'($signed(ua[31:0]));
      sb = longint'($signed(ub[31:0]));
    end else begin
      sa = $signed(ua);
      sb = $signed(ub);
    end
    if (ub == 64'h0) return is_rem ? ua : mask;
    if (sgn) begin
      if (ua == min_v && ub == mask) return is_rem ? 64'h0 : min_v;
      return (is_rem ? 64'(sa % sb) : 64'(sa / sb)) & mask;
    end
    return is_rem ? (ua % ub) : (ua / ub);
  endfunction

  // Cycles from the accept edge until valid_o is seen high.
  function automatic int ref_latency(div_opcode_e op, logic [63:0] b, int w,
                                     int bpc, logic dit);
    logic [63:0] mask, ub, mag;
    int          l, msb;
    if (dit) return w / bpc + 1;
    mask = width_mask(w);
    ub   = b & mask;
    mag  = ((op == DIV_DIV || op == DIV_REM) && ub[w-1]) ? ((-ub) & mask) : ub;
    if (mag == 64'h0) begin
      l = w - 1;
    end else begin
      msb = $clog2({1'b0, mag} + 65'd1) - 1;
      l   = w - 1 - msb;
    end
    return (l + 1 + bpc - 1) / bpc + 1;
  endfunction

  function automatic logic [63:0] rand_operand(int w);
    logic [63:0] v;
    case ($urandom_range(0, 4))
      0:       v = 64'($urandom_range(0, 40));
      1:       v = {$urandom, $urandom};
      2:       v = 64'h0;
      3:       v = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      default: v = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return v & width_mask(w);
  endfunction

  // ---------------- driver ----------------
  // Presents one request, waits for valid_o (bounded), optionally holds
  // ready_i low for 'hold' cycles, then completes the handshake.
  task automatic drive_op(input logic sel64, input div_opcode_e op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic dit, input int hold, input logic keep_valid,
                          output logic [63:0] res, output int lat,
                          output logic stable, output logic hs_ready,
                          output logic busy_ready);
    @(negedge clk);
    use64 = sel64; drv_op = op; drv_a = a; drv_b = b; drv_dit = dit;
    drv_valid = 1'b1; drv_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0; busy_ready = 1'b0;
    while (!mon_valid_o && lat < 200) begin
      if (mon_ready_o) busy_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = mon_result; stable = mon_valid_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (mon_result !== res || !mon_valid_o) stable = 1'b0;
    end
    drv_ready = 1'b1; #1;
    hs_ready = mon_ready_o;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    if (!keep_valid) drv_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; use64 = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0;
    drv_op = DIV_DIV; drv_a = '0; drv_b = '0; drv_dit = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (if32.valid_o !== 1'b0) $display("FAIL reset_valid32 got %b exp 0", if32.valid_o); else n_pass++;
    n_checks++; if (if32.result_o !== 32'h0) $display("FAIL reset_result32 got %h exp 0", if32.result_o); else n_pass++;
    n_checks++; if (if32.ready_o !== 1'b1) $display("FAIL reset_ready32 got %b exp 1", if32.ready_o); else n_pass++;
    n_checks++; if (dbg32 !== DIVR_IDLE) $display("FAIL reset_state32 got %0d exp %0d", dbg32, DIVR_IDLE); else n_pass++;
    n_checks++; if (if64.valid_o !== 1'b0 || if64.result_o !== 64'h0)
      $display("FAIL reset_out64 got valid %b result %h exp 0/0", if64.valid_o, if64.result_o); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  typedef struct {
    div_opcode_e op; logic [63:0] a; logic [63:0] b; logic dit;
    logic [63:0] exp_res; int exp_lat;
  } vec_t;

  task automatic test_directed32();
    vec_t        v[8];
    logic [63:0] res; int lat; logic st, hs, busy;
    v[0] = '{DIV_DIV,  64'd100,        64'd7,          1'b0, 64'd14,         31};
    v[1] = '{DIV_REM,  64'hFFFF_FFF9,  64'd2,          1'b0, 64'hFFFF_FFFF,  32};
    v[2] = '{DIV_DIVU, 64'd5,          64'd0,          1'b0, 64'hFFFF_FFFF,  33};
    v[3] = '{DIV_REMU, 64'd5,          64'd0,          1'b0, 64'd5,          33};
    v[4] = '{DIV_DIV,  64'h8000_0000,  64'hFFFF_FFFF,  1'b0, 64'h8000_0000,  33};
    v[5] = '{DIV_REM,  64'h8000_0000,  64'hFFFF_FFFF,  1'b0, 64'h0,          33};
    v[6] = '{DIV_DIVU, 64'd1,          64'h8000_0000,  1'b1, 64'h0,          33};
    v[7] = '{DIV_DIVU, 64'd1,          64'd1,          1'b1, 64'd1,          33};
    for (int i = 0; i < 8; i++) begin
      drive_op(1'b0, v[i].op, v[i].a, v[i].b, v[i].dit, 2, 1'b0, res, lat, st, hs, busy);
      n_checks++; if (res !== v[i].exp_res) $display("FAIL dir%0d_result got %h exp %h", i, res, v[i].exp_res); else n_pass++;
      n_checks++; if (lat !== v[i].exp_lat) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, v[i].exp_lat); else n_pass++;
      n_checks++; if (hs !== 1'b1 || st !== 1'b1) $display("FAIL dir%0d_handshake got ready %b stable %b exp 1/1", i, hs, st); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL dir%0d_busy_ready got %b exp 0", i, busy); else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [63:0] res; int lat; logic st, hs, busy, seen;
    @(negedge clk);
    use64 = 1'b0; drv_op = DIV_DIV; drv_a = 64'd100; drv_b = 64'd7; drv_dit = 1'b0;
    drv_valid = 1'b1; drv_ready = 1'b0;
    @(posedge clk); #1;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (dbg32 !== DIVR_DIVIDE || if32.ready_o !== 1'b0)
      $display("FAIL abort_busy got state %0d ready %b exp %0d/0", dbg32, if32.ready_o, DIVR_DIVIDE); else n_pass++;
    drv_valid = 1'b0; #1;
    n_checks++; if (if32.ready_o !== 1'b1 || if32.valid_o !== 1'b0)
      $display("FAIL abort_kill got ready %b valid %b exp 1/0", if32.ready_o, if32.valid_o); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (dbg32 !== DIVR_IDLE) $display("FAIL abort_idle got %0d exp %0d", dbg32, DIVR_IDLE); else n_pass++;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (if32.valid_o) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_result got %b exp 0", seen); else n_pass++;
    drive_op(1'b0, DIV_DIV, 64'd9, 64'd3, 1'b0, 0, 1'b0, res, lat, st, hs, busy);
    n_checks++; if (res !== 64'd3) $display("FAIL abort_next_result got %h exp 3", res); else n_pass++;
    n_checks++; if (lat !== 32) $display("FAIL abort_next_latency got %0d exp 32", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int lat; logic st, hs, busy;
    drive_op(1'b0, DIV_DIVU, 64'd50, 64'd5, 1'b0, 0, 1'b1, res, lat, st, hs, busy);
    n_checks++; if (res !== 64'd10) $display("FAIL b2b_first got %h exp a", res); else n_pass++;
    drive_op(1'b0, DIV_DIVU, 64'd1000, 64'd10, 1'b0, 0, 1'b0, res, lat, st, hs, busy);
    n_checks++; if (res !== 64'd100) $display("FAIL b2b_second got %h exp 64", res); else n_pass++;
    n_checks++; if (lat !== ref_latency(DIV_DIVU, 64'd10, 32, 1, 1'b0))
      $display("FAIL b2b_latency got %0d exp %0d", lat, ref_latency(DIV_DIVU, 64'd10, 32, 1, 1'b0)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    use64 = 1'b0; drv_op = DIV_DIVU; drv_a = 64'd77; drv_b = 64'd5; drv_dit = 1'b0;
    drv_valid = 1'b1; drv_ready = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; drv_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dbg32 !== DIVR_IDLE || if32.valid_o !== 1'b0 || if32.result_o !== 32'h0)
      $display("FAIL midreset got state %0d valid %b result %h exp idle/0/0", dbg32, if32.valid_o, if32.result_o); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (if32.valid_o) seen++; end
    n_checks++; if (seen !== 0) $display("FAIL midreset_no_result got %0d exp 0", seen); else n_pass++;
  endtask

  task automatic test_w64();
    logic [63:0] res; int lat; logic st, hs, busy;
    drive_op(1'b1, DIV_DIVU, 64'h8000_0000_0000_0000, 64'd3, 1'b0, 4, 1'b0, res, lat, st, hs, busy);
    n_checks++; if (res !== 64'h2AAA_AAAA_AAAA_AAAA) $display("FAIL w64_result got %h exp 2aaaaaaaaaaaaaaa", res); else n_pass++;
    n_checks++; if (lat !== 33) $display("FAIL w64_latency got %0d exp 33", lat); else n_pass++;
    n_checks++; if (st !== 1'b1 || hs !== 1'b1) $display("FAIL w64_stall got stable %b ready %b exp 1/1", st, hs); else n_pass++;
  endtask

  task automatic test_random(input logic sel64, input int count);
    logic [63:0] res, a, b, exp_r; int lat, w, bpc, exp_l; logic st, hs, busy, dit;
    div_opcode_e op;
    w = sel64 ? 64 : 32; bpc = sel64 ? 2 : 1;
    for (int i = 0; i < count; i++) begin
      op  = div_opcode_e'($urandom_range(0, 3));
      a   = rand_operand(w);
      b   = rand_operand(w);
      dit = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_result(op, a, b, w));
      exp_l = ref_latency(op, b, w, bpc, dit);
      drive_op(sel64, op, a, b, dit, $urandom_range(0, 2), 1'b0, res, lat, st, hs, busy);
      exp_r = exp_q.pop_front();
      n_checks++; if (res !== exp_r)
        $display("FAIL rand%0d_w%0d_result op %0d a %h b %h got %h exp %h", i, w, op, a, b, res, exp_r); else n_pass++;
      n_checks++; if (lat !== exp_l)
        $display("FAIL rand%0d_w%0d_latency b %h dit %b got %0d exp %0d", i, w, b, dit, lat, exp_l); else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed32();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_w64();
    test_random(1'b0, 24);
    test_random(1'b1, 12);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40s_div_radix.md
CV32E40S_DIV_RADIX -- requirements
Module: cv32e40s_div_radix

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; legal values 32, 64.
REQ-002 Parameter BITS_PER_CYCLE, default 1: quotient bits retired per DIVIDE cycle; legal values 1, 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 operator_i  input  div_opcode_e  DIV_DIV, DIV_DIVU, DIV_REM or DIV_REMU; sampled at accept.
REQ-006 data_ind_timing_i  input  1  when high at accept, latency is operand-independent.
REQ-007 op_a_i  input  WIDTH  dividend; sampled at accept.
REQ-008 op_b_i  input  WIDTH  divisor; sampled at accept.
REQ-009 valid_i  input  1  operation request; low at any time kills the operation.
REQ-010 ready_o  output  1  operation consumed or killed.
REQ-011 valid_o  output  1  result_o holds a valid result.
REQ-012 ready_i  input  1  downstream accepts the result.
REQ-013 result_o  output  WIDTH  quotient or remainder.

Function
REQ-014 States: DIVR_IDLE, DIVR_DIVIDE, DIVR_FINISH.
REQ-015 Accept: in DIVR_IDLE with valid_i high, operator, operands and data_ind_timing_i are registered, and the FSM moves to DIVR_DIVIDE.
REQ-016 Signed operations use magnitudes |a| and |b| as unsigned WIDTH-bit values; |MIN| equals 2^(WIDTH-1).
REQ-017 At accept, the divisor magnitude is normalised left by L = clz(|b|) using the internal CLZ, and the iteration count is N = ceil((L+1)/BITS_PER_CYCLE).
REQ-018 With data_ind_timing_i high, N = WIDTH/BITS_PER_CYCLE; iterations beyond ceil((L+1)/BITS_PER_CYCLE) are dummy cycles that leave quotient/remainder unchanged.
REQ-019 Each DIVIDE cycle performs BITS_PER_CYCLE restoring compare-subtract steps, shifting the divisor right one bit per step and the quotient left one bit per step.
REQ-020 After N DIVIDE cycles the FSM enters DIVR_FINISH, so valid_o rises exactly N+1 cycles after the accept edge.
REQ-021 Divide by zero: DIVU/DIV give all ones; REMU/REM give op_a_i unchanged; the early-term count uses L = WIDTH-1.
REQ-022 Overflow: DIV of MIN by -1 gives MIN; REM of MIN by -1 gives 0.
REQ-023 Sign fix: the quotient is negated iff signed, b != 0, and sign(a) != sign(b); the remainder is negated iff signed and a is negative.
REQ-024 In DIVR_FINISH, valid_o is 1 and result_o is stable; when ready_i is 1, ready_o is 1 in the same cycle and the next state is DIVR_IDLE.
REQ-025 valid_i low in any state forces next state DIVR_IDLE, ready_o 1, and valid_o 0 in that cycle.
REQ-026 ready_o is 0 in DIVR_IDLE and DIVR_DIVIDE while valid_i is high.
REQ-027 A new operation may be accepted in the cycle after a completing FINISH; there is no back-to-back accept in the same cycle.

Reset
REQ-028 On a rising clk edge with rst_n low, the state becomes DIVR_IDLE and all datapath registers and the counter become 0.
REQ-029 During and after reset, valid_o is 0, ready_o follows REQ-025, and result_o is 0.
REQ-030 A reset asserted mid-DIVIDE discards the operation without producing a result.

Structure
REQ-031 The package cv32e40s_pkg holds div_opcode_e and the new div_radix_state_e; no other new package items.
REQ-032 One sub-module, cv32e40s_div_clz, is instantiated: a WIDTH-parametrised leading-zero counter with a $clog2(WIDTH)+1-bit output.
REQ-033 The block uses no ALU CLZ/shifter interface; it is self-contained.

Verification
REQ-034 WIDTH=32, BPC=1, DIV 100 / 7 -> result 14, valid_o 31 cycles after accept (L=29, N=30).
REQ-035 REM -7 / 2 -> 0xFFFFFFFF (-1); DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
REQ-037 data_ind_timing_i=1, DIVU 1 / 0x80000000 and 1 / 1 -> both reach valid_o 33 cycles after accept; results 0 and 1.
REQ-038 Drop valid_i in DIVIDE cycle 5 -> ready_o=1 the same cycle, valid_o stays 0, the next op 9/3 accepted afterwards returns 3.
REQ-039 WIDTH=64, BPC=2, DIVU 2^63 / 3 -> 0x2AAAAAAAAAAAAAAA, valid_o 33 cycles after accept (L=62, N=32); hold ready_i=0 for 4 cycles -> result stable.
